// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter.
// Inhibit, request-to-send, shift 10 frame bits, then wait for ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_WAIT_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t state;

  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic dev_fall;
  logic active;
  logic timeout;

  assign dev_fall = clk_prev & ~clk_sync;
  assign active   = (state == S_RTS) || (state == S_SHIFT) ||
                    (state == S_WAIT_ACK) || (state == S_WAIT_IDLE);
  assign timeout  = active && (to_cnt == TO_LAST);
  assign busy     = ~tx_ready;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  // Transfer FSM; line drives and status pulses are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (timeout) begin
        // Timeout wins over any edge seen in the same cycle.
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_err      <= 1'b1;
        tx_ready    <= 1'b1;
        state       <= S_IDLE;
      end else begin
        if (active) to_cnt <= to_cnt + TW'(1);
        unique case (state)
          S_IDLE: begin
            if (tx_valid && tx_ready) begin
              frame       <= {1'b1, ~^tx_data, tx_data};
              inh_cnt     <= '0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              tx_ready    <= 1'b0;
              state       <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (ps2_data_oe) begin
              ps2_clk_oe <= 1'b0;
              bit_cnt    <= '0;
              to_cnt     <= '0;
              state      <= S_RTS;
            end else if (inh_cnt == INH_LAST) begin
              ps2_data_oe <= 1'b1;
            end else begin
              inh_cnt <= inh_cnt + IW'(1);
            end
          end
          S_RTS, S_SHIFT: begin
            if (dev_fall && bit_cnt < 4'd10) begin
              ps2_data_oe <= ~frame[bit_cnt];
              if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
              state <= (bit_cnt == 4'd9) ? S_WAIT_ACK : S_SHIFT;
            end
          end
          S_WAIT_ACK: begin
            ps2_data_oe <= 1'b0;
            if (dev_fall) begin
              if (!data_sync) begin
                state <= S_WAIT_IDLE;
              end else begin
                tx_err   <= 1'b1;
                tx_ready <= 1'b1;
                state    <= S_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end
          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device plus scoreboard.
// Expected frames/outcomes are queued at issue, checked on pulses.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TMO  = 4000;
  localparam int HALF = 20;

  logic       clk, rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_done, tx_err, busy;
  logic       dev_clk, dev_data;

  typedef struct {
    logic [10:0] frame;
    int          kind;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  int          npulse;
  int          issued;
  int          cyc;
  int          rts_cyc;
  logic [10:0] cap;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYC(INH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_i(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  // Reference frame as the device sees it: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  // Scoreboard monitor: every done/err pulse consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (tx_done || tx_err)) begin
        npulse++;
        if (sb.size() == 0) begin
          check_i("unexpected_pulse", 1, 0);
        end else begin
          e = sb.pop_front();
          check_i("tx_done", int'(tx_done), int'(e.kind == 0));
          check_i("tx_err", int'(tx_err), int'(e.kind != 0));
          check_i("ready_at_pulse", int'(tx_ready), 1);
          check_i("oe_at_pulse", int'({ps2_clk_oe, ps2_data_oe}), 0);
          if (e.kind == 2)
            check_i("timeout_latency", cyc - rts_cyc, TMO);
          else
            check_i("frame_bits", int'(cap), int'(e.frame));
        end
      end
    end
  end

  // Device model: mode 0 ACK, 1 NACK, 2 never clocks.
  task automatic device(input int mode, input bit garble,
                        input int rst_edge, input logic [10:0] fr);
    int n;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_i("inhibit_start", int'(ps2_clk_oe), 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 4 * INH) begin
      @(negedge clk);
      n++;
    end
    check_i("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_i("rts_overlap", n, 1);
    check_i("rts_lines", int'({ps2_clk_oe, ps2_data_oe}), 1);
    rts_cyc = cyc;
    cap = '0;
    if (mode == 2) return;
    cap[0] = ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && mode == 0) dev_data = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (garble && i == 2) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      repeat (HALF) @(negedge clk);
      if (i <= 10) cap[i] = ps2_data_in;
      if (garble && i == 5) tx_valid = 1'b0;
      if (i == rst_edge) begin
        check_i("pre_reset_bits", int'(cap[5:0]), int'(fr[5:0]));
        #3 rst = 1'b1;
        #1;
        check_i("reset_lines", int'({ps2_clk_oe, ps2_data_oe}), 0);
        check_i("reset_ready", int'({tx_ready, busy}), 2);
        check_i("reset_pulses", int'({tx_done, tx_err}), 0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        return;
      end
      dev_clk = 1'b1;
      if (i == 11) dev_data = 1'b1;
    end
  endtask

  task automatic run(input logic [7:0] d, input int mode,
                     input bit garble, input int rst_edge);
    exp_t e;
    int   n;
    e.frame = frame_of(d);
    e.kind  = mode;
    if (rst_edge == 0) begin
      sb.push_back(e);
      issued++;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    device(mode, garble, rst_edge, e.frame);
    n = 0;
    while (npulse < issued && n < TMO + 1000) begin
      @(negedge clk);
      n++;
    end
    check_i("pulse_count", npulse, issued);
    repeat (5) @(negedge clk);
    check_i("idle_ready", int'({tx_ready, busy}), 2);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    npulse   = 0;
    issued   = 0;
    cyc      = 0;
    rts_cyc  = 0;
    cap      = '0;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check_i("rst_ready", int'({tx_ready, busy}), 2);
    check_i("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    check_i("rst_pulses", int'({tx_done, tx_err}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(8'hED, 0, 1'b0, 0);
    run(8'h00, 0, 1'b0, 0);
    run(8'h01, 0, 1'b0, 0);
    run(8'h3C, 1, 1'b0, 0);
    run(8'hA5, 2, 1'b0, 0);
    run(8'h5A, 0, 1'b1, 5);
    run(8'hC3, 0, 1'b1, 0);
    for (int k = 0; k < 6; k++)
      run(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 1'b0, 0);
    repeat (50) @(negedge clk);
    check_i("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
